// File: rtl/lock_key_pkg.sv
// Shared types and constants for the logic-locking key loader.
// Holds the loader state enum and the default key width.
// Optional feature macro: KEY_PARITY_EN adds the PARITY state.
package lock_key_pkg;

  // Default number of key bits driven onto the locked netlist's D inputs.
  localparam int unsigned KEY_W_DEF = 10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
`ifdef KEY_PARITY_EN
    ST_PARITY = 2'd2,
`endif
    ST_COMMIT = 2'd3
  } lk_state_e;

endpackage : lock_key_pkg

// File: rtl/lock_key_loader.sv
// Serial key loader for a logic-locked netlist.
// Shifts KEY_W bits (LSB first) into a shadow register and commits them to
// key_out in one step, so the netlist never sees a partially loaded key.
// Optional feature macro: KEY_PARITY_EN -- one trailing odd-parity bit is
// accepted and checked; a bad parity sets the sticky err flag instead of
// committing.
//
// Ports:
//   clk        sole clock, rising edge
//   rst        asynchronous active-high reset
//   start      one-cycle request to (re)start a load; aborts a load in flight
//   bit_valid  serial key bit present on bit_data
//   bit_data   serial key bit, D_0 first
//   bit_ready  loader accepts a bit this cycle (SHIFT/PARITY)
//   key_out    committed key
//   key_valid  key_out holds a committed key
//   busy       load in progress
//   done       one-cycle pulse on successful commit
//   err        sticky parity error, cleared by the next start
module lock_key_loader
  import lock_key_pkg::*;
#(
  parameter int unsigned KEY_W = KEY_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             bit_valid,
  input  logic             bit_data,
  output logic             bit_ready,
  output logic [KEY_W-1:0] key_out,
  output logic             key_valid,
  output logic             busy,
  output logic             done,
  output logic             err
);

  // Counter holds 0..KEY_W so it can never wrap within a load.
  localparam int unsigned CNT_W = $clog2(KEY_W + 1);

  lk_state_e               state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [KEY_W-1:0]        shadow_q, shadow_d;
  logic [KEY_W-1:0]        key_out_q, key_out_d;
  logic                    key_valid_q, key_valid_d;
  logic                    bit_ready_q;
  logic                    busy_q;
  logic                    done_q;
`ifdef KEY_PARITY_EN
  logic                    err_q, err_d;
`endif

  // Next-state and datapath update; start has priority in every state.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shadow_d    = shadow_q;
    key_out_d   = key_out_q;
    key_valid_d = key_valid_q;
`ifdef KEY_PARITY_EN
    err_d       = err_q;
`endif
    if (start) begin
      // Restart; a bit offered in this same cycle is dropped.
      state_d     = ST_SHIFT;
      cnt_d       = '0;
      shadow_d    = '0;
      key_valid_d = 1'b0;
`ifdef KEY_PARITY_EN
      err_d       = 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_IDLE;
        end
        ST_SHIFT: begin
          if (bit_valid) begin
            // Shadow is cleared on start, so OR-ing sets bit cnt_q exactly.
            shadow_d = shadow_q | (KEY_W'(bit_data) << cnt_q);
            if (cnt_q == CNT_W'(KEY_W - 1)) begin
`ifdef KEY_PARITY_EN
              state_d = ST_PARITY;
`else
              state_d = ST_COMMIT;
`endif
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
`ifdef KEY_PARITY_EN
        ST_PARITY: begin
          if (bit_valid) begin
            // Odd parity over data bits plus the parity bit.
            if ((^shadow_q) ^ bit_data) begin
              state_d = ST_COMMIT;
            end else begin
              err_d   = 1'b1;
              state_d = ST_IDLE;
            end
          end
        end
`endif
        ST_COMMIT: begin
          key_out_d   = shadow_q;
          key_valid_d = 1'b1;
          state_d     = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State and registered outputs; status flags follow the next state so
  // they line up with the state they describe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      shadow_q    <= '0;
      key_out_q   <= '0;
      key_valid_q <= 1'b0;
      bit_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef KEY_PARITY_EN
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shadow_q    <= shadow_d;
      key_out_q   <= key_out_d;
      key_valid_q <= key_valid_d;
`ifdef KEY_PARITY_EN
      bit_ready_q <= (state_d == ST_SHIFT) || (state_d == ST_PARITY);
      err_q       <= err_d;
`else
      bit_ready_q <= (state_d == ST_SHIFT);
`endif
      busy_q      <= (state_d != ST_IDLE);
      done_q      <= (state_d == ST_COMMIT);
    end
  end

  assign bit_ready = bit_ready_q;
  assign key_out   = key_out_q;
  assign key_valid = key_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;
`ifdef KEY_PARITY_EN
  assign err       = err_q;
`else
  assign err       = 1'b0;
`endif

endmodule : lock_key_loader

// File: tb/tb_lock_key_loader.sv
// Directed self-checking bench for lock_key_loader (KEY_W = 10).
module tb_lock_key_loader;

  localparam int unsigned KW = 10;
`ifdef KEY_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic          clk = 1'b0;
  logic          rst, start, bit_valid, bit_data;
  logic          bit_ready, key_valid, busy, done, err;
  logic [KW-1:0] key_out;

  lock_key_loader #(.KEY_W(KW)) dut (
    .clk(clk), .rst(rst), .start(start), .bit_valid(bit_valid),
    .bit_data(bit_data), .bit_ready(bit_ready), .key_out(key_out),
    .key_valid(key_valid), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic          st, bv, bd;
    logic          e_rdy, e_busy, e_done, e_valid;
    logic [KW-1:0] e_key;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic st, bv, bd, rdy, bsy, dn, vl,
                              input logic [KW-1:0] k);
    vec_t v;
    v.st = st; v.bv = bv; v.bd = bd;
    v.e_rdy = rdy; v.e_busy = bsy; v.e_done = dn; v.e_valid = vl; v.e_key = k;
    tbl.push_back(v);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Drive one cycle of inputs at negedge; return 1 time unit after the posedge.
  task automatic cyc(input logic s, input logic v, input logic d);
    @(negedge clk);
    start = s; bit_valid = v; bit_data = d;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; start = 1'b0; bit_valid = 1'b0; bit_data = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Full load: start, KW bits, optional parity bit p; returns done pulses seen.
  task automatic load(input logic [KW-1:0] kk, input logic p, output int dn);
    dn = 0;
    cyc(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < int'(KW); i++) begin
      cyc(1'b0, 1'b1, kk[i]);
      dn += int'(done);
    end
    if (PAR == 1) begin
      cyc(1'b0, 1'b1, p);
      dn += int'(done);
    end
  endtask

  logic [KW-1:0] k;
  logic [KW-1:0] k2;
  int            dn, cnt, seen;

  initial begin
    rst = 1'b1; start = 1'b0; bit_valid = 1'b0; bit_data = 1'b0;
    #12;
    chk("reset key_out", 32'(key_out), 32'h0);
    chk("reset flags", {28'h0, bit_ready, key_valid, busy, done}, 32'h0);
    chk("reset err", 32'(err), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Back-to-back load of 10'h29C (bits 0,0,1,1,1,0,0,1,0,1).
    k = 10'h29C;
    add(1, 0, 0, 1, 1, 0, 0, '0);
    for (int i = 0; i < int'(KW); i++) begin
`ifdef KEY_PARITY_EN
      add(0, 1, k[i], 1, 1, 0, 0, '0);
`else
      if (i == int'(KW) - 1) add(0, 1, k[i], 0, 1, 1, 0, '0);
      else                   add(0, 1, k[i], 1, 1, 0, 0, '0);
`endif
    end
`ifdef KEY_PARITY_EN
    add(0, 1, 0, 0, 1, 1, 0, '0);
`endif
    add(0, 0, 0, 0, 0, 0, 1, 10'h29C);
    add(0, 1, 1, 0, 0, 0, 1, 10'h29C);
    add(0, 0, 0, 0, 0, 0, 1, 10'h29C);

    for (int i = 0; i < tbl.size(); i++) begin
      cyc(tbl[i].st, tbl[i].bv, tbl[i].bd);
      chk($sformatf("vec%0d bit_ready", i), 32'(bit_ready), 32'(tbl[i].e_rdy));
      chk($sformatf("vec%0d busy", i),      32'(busy),      32'(tbl[i].e_busy));
      chk($sformatf("vec%0d done", i),      32'(done),      32'(tbl[i].e_done));
      chk($sformatf("vec%0d key_valid", i), 32'(key_valid), 32'(tbl[i].e_valid));
      chk($sformatf("vec%0d key_out", i),   32'(key_out),   32'(tbl[i].e_key));
      chk($sformatf("vec%0d err", i),       32'(err),       32'h0);
    end

    // Same key with a 3-cycle stall after bit 4.
    do_reset();
    chk("stall reset key", 32'(key_out), 32'h0);
    cyc(1'b1, 1'b0, 1'b0);
    cnt = 0; seen = -1;
    for (int i = 0; i < int'(KW) + PAR; i++) begin
      cyc(1'b0, 1'b1, (i < int'(KW)) ? k[i] : ~^k);
      cnt++;
      if (done && seen < 0) seen = cnt;
      if (i == 4) begin
        for (int j = 0; j < 3; j++) begin
          cyc(1'b0, 1'b0, 1'b0);
          cnt++;
          if (done && seen < 0) seen = cnt;
          chk("stall ready held", 32'(bit_ready), 32'h1);
          chk("stall key hidden", 32'(key_out), 32'h0);
        end
      end
      if (i < int'(KW) + PAR - 1) chk("stall key hidden", 32'(key_out), 32'h0);
    end
    chk("stall done cycle", 32'(seen), 32'(int'(KW) + PAR + 3));
    chk("stall key at done", 32'(key_out), 32'h0);
    cyc(1'b0, 1'b0, 1'b0);
    chk("stall key_out", 32'(key_out), 32'h29C);
    chk("stall key_valid", 32'(key_valid), 32'h1);

    // Abort after 6 bits, restart (bit offered with start is dropped), load 10'h155.
    dn = 0;
    cyc(1'b1, 1'b0, 1'b0);
    chk("reload valid cleared", 32'(key_valid), 32'h0);
    for (int i = 0; i < 6; i++) begin
      cyc(1'b0, 1'b1, k[i]);
      dn += int'(done);
      chk("reload valid low", 32'(key_valid), 32'h0);
    end
    k2 = 10'h155;
    cyc(1'b1, 1'b1, 1'b1);
    chk("restart busy", 32'(busy), 32'h1);
    for (int i = 0; i < int'(KW) + PAR; i++) begin
      cyc(1'b0, 1'b1, (i < int'(KW)) ? k2[i] : ~^k2);
      dn += int'(done);
      if (i < int'(KW) + PAR - 1) chk("reload valid low", 32'(key_valid), 32'h0);
    end
    cyc(1'b0, 1'b0, 1'b0);
    dn += int'(done);
    chk("reload done count", 32'(dn), 32'h1);
    chk("reload key_out", 32'(key_out), 32'h155);
    chk("reload key_valid", 32'(key_valid), 32'h1);

    // Asynchronous reset after the 5th bit.
    cyc(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("async rst key_out", 32'(key_out), 32'h0);
    chk("async rst flags", {28'h0, bit_ready, key_valid, busy, done}, 32'h0);
    chk("async rst err", 32'(err), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    cyc(1'b1, 1'b0, 1'b0);
    chk("first start busy", 32'(busy), 32'h1);
    chk("first start ready", 32'(bit_ready), 32'h1);
    k2 = 10'h3FF;
    for (int i = 0; i < int'(KW) + PAR; i++)
      cyc(1'b0, 1'b1, (i < int'(KW)) ? k2[i] : ~^k2);
    chk("3FF done", 32'(done), 32'h1);
    cyc(1'b0, 1'b0, 1'b0);
    chk("3FF key_out", 32'(key_out), 32'h3FF);
    chk("3FF key_valid", 32'(key_valid), 32'h1);

`ifdef KEY_PARITY_EN
    // Good parity commits, bad parity flags err and keeps key_out.
    load(10'h29C, 1'b0, dn);
    chk("par good done", 32'(dn), 32'h1);
    cyc(1'b0, 1'b0, 1'b0);
    chk("par good key", 32'(key_out), 32'h29C);
    load(10'h29C, 1'b1, dn);
    chk("par bad done", 32'(dn), 32'h0);
    chk("par bad err", 32'(err), 32'h1);
    chk("par bad busy", 32'(busy), 32'h0);
    cyc(1'b0, 1'b0, 1'b0);
    chk("par bad key kept", 32'(key_out), 32'h29C);
    chk("par err sticky", 32'(err), 32'h1);
    chk("par bad no done", 32'(done), 32'h0);
    cyc(1'b1, 1'b0, 1'b0);
    chk("par err cleared", 32'(err), 32'h0);
`else
    load(10'h0A5, 1'b0, dn);
    chk("load A5 done", 32'(dn), 32'h1);
    cyc(1'b0, 1'b0, 1'b0);
    chk("load A5 key", 32'(key_out), 32'h0A5);
    chk("err tied low", 32'(err), 32'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_lock_key_loader

// File: doc/lock_key_loader.md
LOCK_KEY_LOADER -- requirements
Module: lock_key_loader

Interface
REQ-001 Parameter KEY_W SHALL default to 10 and set the number of key bits (bit i drives D_i of the locked netlist).
REQ-002 clk  input  1  sole clock; all state changes on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  one-cycle request to begin loading a new key.
REQ-005 bit_valid  input  1  serial key bit present on bit_data.
REQ-006 bit_data  input  1  serial key bit, LSB (D_0) first.
REQ-007 bit_ready  output  1  loader accepts a bit this cycle.
REQ-008 key_out  output  KEY_W  committed key to the locked netlist's D inputs.
REQ-009 key_valid  output  1  key_out holds a committed key.
REQ-010 busy  output  1  load in progress (any state other than IDLE).
REQ-011 done  output  1  one-cycle pulse on successful commit.
REQ-012 err  output  1  sticky error flag, cleared by the next accepted start.

Function
REQ-013 States SHALL be IDLE, SHIFT, PARITY (only with KEY_PARITY_EN) and COMMIT.
REQ-014 IDLE: start=1 -> SHIFT; bit counter cleared; shadow register cleared; key_valid cleared; err cleared.
REQ-015 bit_ready SHALL be 1 exactly in SHIFT and PARITY; a bit is accepted only on a cycle with bit_valid=1 and bit_ready=1.
REQ-016 In SHIFT, the k-th accepted bit (k=0..KEY_W-1) SHALL be written to shadow[k]; bit_valid=0 stalls with no state change.
REQ-017 After bit KEY_W-1 is accepted: -> PARITY if KEY_PARITY_EN is defined, otherwise -> COMMIT.
REQ-018 COMMIT SHALL last one cycle: key_out <= shadow, key_valid <= 1, done = 1, then -> IDLE.
REQ-019 key_out SHALL change only on the COMMIT clock edge; it never exposes partially shifted bits.
REQ-020 Latency: done SHALL assert exactly 1 cycle after the last bit is accepted (last data bit, or the parity bit).
REQ-021 start=1 while busy SHALL abort and restart: -> SHIFT, counter/shadow cleared, key_valid cleared, err cleared; any bit accepted in that same cycle is discarded.
REQ-022 bit_valid in IDLE or COMMIT SHALL be ignored (bit_ready=0); it is not an error.
REQ-023 The bit counter SHALL be ceil(log2(KEY_W+1)) bits wide and never wrap within a load.

Reset
REQ-024 rst=1 SHALL immediately force state=IDLE, key_out=0, key_valid=0, busy=0, done=0, err=0, bit_ready=0, counter=0, shadow=0, including mid-load.
REQ-025 The first start after reset deassertion SHALL be honoured on the first rising edge.

Configuration
REQ-026 With KEY_PARITY_EN defined: after KEY_W data bits, one extra bit SHALL be accepted in PARITY; if XOR of the data bits and the parity bit is 1 (odd parity) -> COMMIT, else err <= 1, key_out and key_valid unchanged, no done, -> IDLE.
REQ-027 Without KEY_PARITY_EN: PARITY state and the parity check SHALL be absent and err SHALL be tied to 0.

Structure
REQ-028 Shared package lock_key_pkg SHALL hold the state enum type and the KEY_W default constant.
REQ-029 The block SHALL be a single module; no sub-module.

Verification
REQ-030 Reset, then start, then bits 0,0,1,1,1,0,0,1,0,1 back-to-back -> key_out=10'h29C, key_valid=1, done pulse exactly 1 cycle after the 10th bit.
REQ-031 Same key with bit_valid dropped for 3 cycles after bit 4 -> identical key_out=10'h29C; done delayed by exactly 3 cycles; key_out stays 0 until commit.
REQ-032 Commit 10'h29C, then start and 6 bits, then start and bits of 10'h155 -> key_valid=0 during reload, final key_out=10'h155, one done pulse only.
REQ-033 rst asserted after the 5th bit -> all outputs 0 asynchronously; the next full load of 10'h3FF commits correctly.
REQ-034 KEY_PARITY_EN: 10'h29C with parity bit 0 -> commit; with parity bit 1 -> err=1, no done, key_out retains its previous value.
